// File: rtl/spike_encoder.sv
// spike_encoder: rate-coding spike source feeding a neuron's SpikeIn.
// Each channel keeps a programmable rate and a phase accumulator; the
// carry out of the accumulator add is the spike. Rates are loaded at
// runtime over a valid/ready port.
//
// Ports:
//   Clk, Rst          clock (rising edge), async active-low reset
//   SourceAddr        neuron address; low CH_W bits select the channel
//   Enable            run encoding
//   LoadValid/Ready   rate load handshake (LoadReady is combinational)
//   LoadAddr/Rate     channel and rate to load
//   SpikeData         SPIKE_VAL on a spike, else 0 (registered)
//   SpikeValid        SpikeData reflects an accumulation (registered)
//   SpikeCount        saturating total of emitted spikes (registered)
module spike_encoder #(
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned CH_W      = 3,
  parameter int unsigned RATE_W    = 8,
  parameter int unsigned SPIKE_VAL = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       SourceAddr,
  input  logic              Enable,
  input  logic              LoadValid,
  output logic              LoadReady,
  input  logic [CH_W-1:0]   LoadAddr,
  input  logic [RATE_W-1:0] LoadRate,
  output logic [31:0]       SpikeData,
  output logic              SpikeValid,
  output logic [15:0]       SpikeCount
);

  localparam int unsigned SUM_W = RATE_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state, state_next;

  logic [RATE_W-1:0] rate_q [CHANNELS];
  logic [RATE_W-1:0] acc_q  [CHANNELS];

  logic [CH_W-1:0]  ch_c;
  logic             handshake_c;
  logic             accum_c;
  logic             collide_c;
  logic [SUM_W-1:0] sum_c;
  logic             spike_c;
  logic             addr_unused_c;

  // Only the low address bits pick a channel; upper bits wrap freely.
  assign ch_c          = SourceAddr[CH_W-1:0];
  assign addr_unused_c = ^SourceAddr[31:CH_W];

  // Handshake and accumulation qualifiers.
  always_comb begin
    LoadReady   = (state != LOAD);
    handshake_c = LoadValid && LoadReady;
    accum_c     = (state == RUN) && Enable;
    collide_c   = handshake_c && (LoadAddr == ch_c);
    sum_c       = SUM_W'(acc_q[ch_c]) + SUM_W'(rate_q[ch_c]);
    // A load on the visited channel wins and suppresses this cycle's spike.
    spike_c     = accum_c && sum_c[RATE_W] && !collide_c;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake_c)  state_next = LOAD;
        else if (Enable)  state_next = RUN;
      end
      RUN: begin
        if (handshake_c)  state_next = LOAD;
        else if (!Enable) state_next = IDLE;
      end
      LOAD: begin
        state_next = Enable ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // Per-channel rate and accumulator storage.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        rate_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      if (accum_c && !collide_c) acc_q[ch_c] <= sum_c[RATE_W-1:0];
      if (handshake_c) begin
        rate_q[LoadAddr] <= LoadRate;
        acc_q[LoadAddr]  <= '0;
      end
    end
  end

  // Registered spike outputs and saturating spike counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      SpikeData  <= '0;
      SpikeValid <= 1'b0;
      SpikeCount <= '0;
    end else begin
      SpikeData  <= spike_c ? 32'(SPIKE_VAL) : 32'd0;
      SpikeValid <= accum_c;
      if (spike_c && (SpikeCount != 16'hFFFF)) SpikeCount <= SpikeCount + 16'd1;
    end
  end

endmodule
